// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared types and constants for the trace run-control block
package trdb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    TRDB_IDLE  = 2'd0,
    TRDB_RUN   = 2'd1,
    TRDB_FLUSH = 2'd2,
    TRDB_DRAIN = 2'd3
  } trdb_ctrl_state_t;

  localparam logic [1:0] TRDB_REG_CTRL    = 2'd0;
  localparam logic [1:0] TRDB_REG_ADDR_LO = 2'd1;
  localparam logic [1:0] TRDB_REG_ADDR_HI = 2'd2;
  localparam logic [1:0] TRDB_REG_STATUS  = 2'd3;

  localparam int TRDB_ST_STATE_LSB = 0;
  localparam int TRDB_ST_OVF_BIT   = 2;
  localparam int TRDB_ST_LEVEL_LSB = 8;
  localparam int TRDB_ST_DROP_LSB  = 16;

endpackage

// File: rtl/trdb_word_fifo.sv
// rtl/trdb_word_fifo.sv - power-of-two word FIFO with level count and combinational head
module trdb_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trdb_trace_ctrl.sv
// rtl/trdb_trace_ctrl.sv - trace enable/window registers, stop sequencing and output word buffering
module trdb_trace_ctrl
  import trdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DROPCNT_W  = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_we_i,
  input  logic [1:0]      cfg_addr_i,
  input  logic [XLEN-1:0] cfg_wdata_i,
  output logic [XLEN-1:0] cfg_rdata_o,
  input  logic            ivalid_i,
  input  logic [XLEN-1:0] iaddr_i,
  output logic            qualified_o,
  output logic            flush_req_o,
  input  logic            flush_ack_i,
  input  logic [XLEN-1:0] word_i,
  input  logic            word_valid_i,
  output logic [XLEN-1:0] trace_data_o,
  output logic            trace_valid_o,
  input  logic            trace_ready_i
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  trdb_ctrl_state_t state, state_next;
  logic             flush_req_d;
  logic             ctrl_en;
  logic [XLEN-1:0]  addr_lo;
  logic [XLEN-1:0]  addr_hi;
  logic             ovf;
  logic [DROPCNT_W-1:0] drop_cnt;

  logic            fifo_full, fifo_empty, push, pop, drop, status_clr;
  logic [LW-1:0]   fifo_level;
  logic [XLEN-1:0] fifo_head;
  logic [XLEN-1:0] status;
  logic [XLEN-1:0] drop_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= TRDB_IDLE;
      flush_req_o <= 1'b0;
    end else begin
      state       <= state_next;
      flush_req_o <= flush_req_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TRDB_IDLE:  if (ctrl_en)                        state_next = TRDB_RUN;
      TRDB_RUN:   if (!ctrl_en)                       state_next = TRDB_FLUSH;
      TRDB_FLUSH: if (flush_ack_i)                    state_next = TRDB_DRAIN;
      TRDB_DRAIN: if (fifo_empty && !word_valid_i)    state_next = TRDB_IDLE;
      default:                                        state_next = TRDB_IDLE;
    endcase
  end

  // Request is registered from the next state so it is high exactly during FLUSH
  always_comb begin
    flush_req_d = (state_next == TRDB_FLUSH);
    qualified_o = ivalid_i && (state == TRDB_RUN) &&
                  (iaddr_i >= addr_lo) && (iaddr_i <= addr_hi);
  end

  assign pop        = !fifo_empty && trace_ready_i;
  assign push       = word_valid_i && (state != TRDB_IDLE) && (!fifo_full || pop);
  assign drop       = word_valid_i && (state != TRDB_IDLE) && fifo_full && !pop;
  assign status_clr = cfg_we_i && (cfg_addr_i == TRDB_REG_STATUS) && cfg_wdata_i[TRDB_ST_OVF_BIT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en  <= 1'b0;
      addr_lo  <= '0;
      addr_hi  <= '1;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (cfg_we_i && cfg_addr_i == TRDB_REG_CTRL)    ctrl_en <= cfg_wdata_i[0];
      if (cfg_we_i && cfg_addr_i == TRDB_REG_ADDR_LO) addr_lo <= cfg_wdata_i;
      if (cfg_we_i && cfg_addr_i == TRDB_REG_ADDR_HI) addr_hi <= cfg_wdata_i;
      // A drop coinciding with a clear counts against the freshly cleared state
      if (drop) begin
        ovf <= 1'b1;
        if (status_clr)       drop_cnt <= DROPCNT_W'(1);
        else if (~&drop_cnt)  drop_cnt <= drop_cnt + DROPCNT_W'(1);
      end else if (status_clr) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  trdb_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (word_i),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign trace_valid_o = !fifo_empty;
  assign trace_data_o  = fifo_empty ? '0 : fifo_head;
  assign drop_ext      = XLEN'(drop_cnt);

  always_comb begin
    status = '0;
    status[TRDB_ST_STATE_LSB +: 2] = state;
    status[TRDB_ST_OVF_BIT]        = ovf;
    status[TRDB_ST_LEVEL_LSB +: 8] = 8'(fifo_level);
    status[TRDB_ST_DROP_LSB +: 16] = drop_ext[15:0];
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      TRDB_REG_CTRL:    cfg_rdata_o = {{(XLEN-1){1'b0}}, ctrl_en};
      TRDB_REG_ADDR_LO: cfg_rdata_o = addr_lo;
      TRDB_REG_ADDR_HI: cfg_rdata_o = addr_hi;
      TRDB_REG_STATUS:  cfg_rdata_o = status;
      default:          cfg_rdata_o = '0;
    endcase
  end

endmodule
